// File: rtl/music_sequencer.sv
// Playback sequencer for one note ROM / music_handler pair: fetches notes from
// song_base onward, holds each for TICK_DIV cycles, and stops or loops on END_CODE.
module music_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                NOTE_W   = 8,
    parameter int                TICK_DIV = 8388608,
    parameter logic [NOTE_W-1:0] END_CODE = 8'hFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] song_base,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_data,
    output logic [NOTE_W-1:0] fullnote,
    output logic              playing,
    output logic              note_step,
    output logic              song_done
);

    localparam int              CNT_W     = $clog2(TICK_DIV);
    // WAIT and LATCH take the last two cycles of every note period.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TICK_DIV - 3);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LATCH, S_HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  counter;
    logic [NOTE_W-1:0] note_reg;
    logic              first_word;
    logic              is_end;

    assign is_end = (rom_data == END_CODE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = S_IDLE;
        end else if (start) begin
            state_next = S_WAIT;
        end else begin
            case (state)
                S_IDLE:  state_next = S_IDLE;
                S_WAIT:  state_next = S_LATCH;
                S_LATCH: begin
                    if (!is_end) begin
                        state_next = S_HOLD;
                    end else if (loop_en && !first_word) begin
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!pause && counter == HOLD_LAST) begin
                        state_next = S_WAIT;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // first_word marks the first fetch of a pass so an empty song cannot refetch forever.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr   <= '0;
            note_reg   <= '0;
            counter    <= '0;
            first_word <= 1'b0;
            note_step  <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            note_step <= 1'b0;
            song_done <= 1'b0;
            if (stop) begin
                note_reg <= '0;
            end else if (start) begin
                rom_addr   <= song_base;
                first_word <= 1'b1;
            end else begin
                case (state)
                    S_LATCH: begin
                        if (!is_end) begin
                            note_reg   <= rom_data;
                            note_step  <= 1'b1;
                            counter    <= '0;
                            first_word <= 1'b0;
                        end else if (loop_en && !first_word) begin
                            rom_addr   <= song_base;
                            first_word <= 1'b1;
                        end else begin
                            note_reg  <= '0;
                            song_done <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!pause) begin
                            counter <= counter + 1'b1;
                            if (counter == HOLD_LAST) begin
                                rom_addr <= rom_addr + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pause only masks the output; note_reg survives and reappears on resume.
    always_comb begin
        playing  = (state != S_IDLE);
        fullnote = pause ? '0 : note_reg;
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: directed vector table, scenario
// sequences and a randomized run against a countdown-based reference model.
module tb_music_sequencer;

    localparam int TICK = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] song_base = 8'h00;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] fullnote;
    logic       playing;
    logic       note_step;
    logic       song_done;

    logic [7:0] mem [256];

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= mem[rom_addr];

    music_sequencer #(
        .ADDR_W(8), .NOTE_W(8), .TICK_DIV(TICK), .END_CODE(8'hFF)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
        .pause(pause), .loop_en(loop_en), .song_base(song_base),
        .rom_addr(rom_addr), .rom_data(rom_data), .fullnote(fullnote),
        .playing(playing), .note_step(note_step), .song_done(song_done)
    );

    // Reference model: a song is "fetching" (edges left until a word is read)
    // or "holding" (unpaused edges left before the next fetch).
    bit         m_active;
    bit         m_first;
    logic [7:0] m_addr;
    logic [7:0] m_note;
    int         m_fetch;
    int         m_hold;
    bit         m_step;
    bit         m_done;

    task automatic model_reset();
        m_active = 1'b0; m_first = 1'b0; m_addr = 8'h00; m_note = 8'h00;
        m_fetch = 0; m_hold = 0; m_step = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] word;
        m_step = 1'b0;
        m_done = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else if (stop) begin
            m_active = 1'b0; m_note = 8'h00; m_fetch = 0;
        end else if (start) begin
            m_active = 1'b1; m_addr = song_base; m_first = 1'b1; m_fetch = 2;
        end else if (m_active) begin
            if (m_fetch > 0) begin
                m_fetch--;
                if (m_fetch == 0) begin
                    word = mem[m_addr];
                    if (word != 8'hFF) begin
                        m_note = word; m_step = 1'b1; m_first = 1'b0; m_hold = TICK - 2;
                    end else if (loop_en && !m_first) begin
                        m_addr = song_base; m_first = 1'b1; m_fetch = 2;
                    end else begin
                        m_active = 1'b0; m_note = 8'h00; m_done = 1'b1;
                    end
                end
            end else if (!pause) begin
                m_hold--;
                if (m_hold == 0) begin
                    m_addr = m_addr + 8'd1;
                    m_fetch = 2;
                end
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output();
        check_val("model.fullnote", 32'(fullnote), 32'(pause ? 8'h00 : m_note));
        check_val("model.rom_addr", 32'(rom_addr), 32'(m_addr));
        check_val("model.playing", 32'(playing), 32'(m_active));
        check_val("model.note_step", 32'(note_step), 32'(m_step));
        check_val("model.song_done", 32'(song_done), 32'(m_done));
    endtask

    task automatic apply_stimulus(input logic s, input logic st, input logic p,
                                  input logic l, input logic [7:0] b);
        @(negedge clock);
        start = s; stop = st; pause = p; loop_en = l; song_base = b;
        @(posedge clock);
        model_edge();
        #1;
        check_output();
    endtask

    int         cyc_q[$];
    logic [7:0] note_q[$];
    logic [7:0] addr_q[$];
    int         done_q[$];
    int         pause_leak;
    logic [7:0] restore_fn;

    // Pulse start on the first cycle, then free-run; pause is high for p_from <= i < p_to.
    task automatic run_capture(input logic [7:0] b, input logic l, input int n,
                               input int p_from, input int p_to);
        cyc_q.delete(); note_q.delete(); addr_q.delete(); done_q.delete();
        pause_leak = 0;
        restore_fn = 8'h00;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(i == 0, 1'b0, (i >= p_from && i < p_to), l, b);
            if (note_step) begin
                cyc_q.push_back(i); note_q.push_back(fullnote); addr_q.push_back(rom_addr);
            end
            if (song_done) done_q.push_back(i);
            if (i >= p_from && i < p_to && fullnote != 8'h00) pause_leak++;
            if (i == p_to) restore_fn = fullnote;
        end
    endtask

    typedef struct {
        logic       start, stop, pause, loop_en;
        logic [7:0] base;
        logic [7:0] fn;
        logic       step, done, play;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic s, input logic st, input logic l, input logic [7:0] b,
                           input logic [7:0] fn, input logic stp, input logic dn, input logic pl);
        vec_t v;
        v.start = s; v.stop = st; v.pause = 1'b0; v.loop_en = l; v.base = b;
        v.fn = fn; v.step = stp; v.done = dn; v.play = pl;
        vecs.push_back(v);
    endtask

    initial begin
        logic p_lvl;
        logic l_lvl;
        logic [7:0] b_rnd;

        for (int i = 0; i < 256; i++) begin
            mem[i] = (i % 11 == 7) ? 8'hFF : (8'(i * 37 + 3) & 8'hFE);
        end
        mem[8'h00] = 8'h21; mem[8'h01] = 8'h35; mem[8'h02] = 8'h40; mem[8'h03] = 8'hFF;
        mem[8'h10] = 8'hFF; mem[8'hFF] = 8'h11;
        model_reset();

        // Empty song, then play into 0x35, simultaneous start+stop, and a clean restart.
        add_vec(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h21, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h21, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h35, 1'b1, 1'b0, 1'b1);
        add_vec(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h21, 1'b1, 1'b0, 1'b1);

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_val("reset.fullnote", 32'(fullnote), 32'h0);
        check_val("reset.rom_addr", 32'(rom_addr), 32'h0);
        check_val("reset.playing", 32'(playing), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].start, vecs[k].stop, vecs[k].pause, vecs[k].loop_en, vecs[k].base);
            check_val($sformatf("vec%0d.fullnote", k), 32'(fullnote), 32'(vecs[k].fn));
            check_val($sformatf("vec%0d.note_step", k), 32'(note_step), 32'(vecs[k].step));
            check_val($sformatf("vec%0d.song_done", k), 32'(song_done), 32'(vecs[k].done));
            check_val($sformatf("vec%0d.playing", k), 32'(playing), 32'(vecs[k].play));
        end

        $display("[TB] basic play");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        run_capture(8'h00, 1'b0, 30, 0, 0);
        check_val("basic.steps", 32'(cyc_q.size()), 32'd3);
        check_val("basic.dones", 32'(done_q.size()), 32'd1);
        if (cyc_q.size() == 3 && done_q.size() == 1) begin
            check_val("basic.first_latency", 32'(cyc_q[0]), 32'd2);
            check_val("basic.note0", 32'(note_q[0]), 32'h21);
            check_val("basic.note1", 32'(note_q[1]), 32'h35);
            check_val("basic.note2", 32'(note_q[2]), 32'h40);
            check_val("basic.gap01", 32'(cyc_q[1] - cyc_q[0]), 32'd8);
            check_val("basic.gap12", 32'(cyc_q[2] - cyc_q[1]), 32'd8);
            check_val("basic.done_gap", 32'(done_q[0] - cyc_q[2]), 32'd8);
        end
        check_val("basic.end_fullnote", 32'(fullnote), 32'h0);
        check_val("basic.end_playing", 32'(playing), 32'h0);

        $display("[TB] loop");
        run_capture(8'h00, 1'b1, 40, 0, 0);
        check_val("loop.steps", 32'(cyc_q.size()), 32'd5);
        check_val("loop.dones", 32'(done_q.size()), 32'd0);
        if (cyc_q.size() == 5) begin
            check_val("loop.note3", 32'(note_q[3]), 32'h21);
            check_val("loop.refetch_gap", 32'(cyc_q[3] - cyc_q[2]), 32'd10);
            check_val("loop.addr3", 32'(addr_q[3]), 32'h00);
            check_val("loop.note4", 32'(note_q[4]), 32'h35);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] pause");
        run_capture(8'h00, 1'b0, 46, 14, 34);
        check_val("pause.steps", 32'(cyc_q.size()), 32'd3);
        check_val("pause.leak", 32'(pause_leak), 32'd0);
        check_val("pause.restore", 32'(restore_fn), 32'h35);
        if (cyc_q.size() == 3) begin
            check_val("pause.step1", 32'(cyc_q[1]), 32'd10);
            check_val("pause.resume_step", 32'(cyc_q[2]), 32'd38);
            check_val("pause.note2", 32'(note_q[2]), 32'h40);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] wrap and reset");
        run_capture(8'hFF, 1'b0, 14, 0, 0);
        check_val("wrap.steps", 32'(cyc_q.size()), 32'd2);
        if (cyc_q.size() == 2) begin
            check_val("wrap.addr0", 32'(addr_q[0]), 32'hFF);
            check_val("wrap.note0", 32'(note_q[0]), 32'h11);
            check_val("wrap.addr1", 32'(addr_q[1]), 32'h00);
            check_val("wrap.note1", 32'(note_q[1]), 32'h21);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        run_capture(8'hFF, 1'b0, 5, 0, 0);
        check_val("hold.fullnote", 32'(fullnote), 32'h11);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_val("async.fullnote", 32'(fullnote), 32'h0);
        check_val("async.rom_addr", 32'(rom_addr), 32'h0);
        check_val("async.playing", 32'(playing), 32'h0);
        check_val("async.note_step", 32'(note_step), 32'h0);
        check_val("async.song_done", 32'(song_done), 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] randomized run");
        p_lvl = 1'b0;
        l_lvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) p_lvl = ~p_lvl;
            if ($urandom_range(0, 99) == 0) l_lvl = ~l_lvl;
            case ($urandom_range(0, 4))
                0: b_rnd = 8'h00;
                1: b_rnd = 8'h10;
                2: b_rnd = 8'hFF;
                3: b_rnd = 8'h02;
                default: b_rnd = 8'($urandom);
            endcase
            apply_stimulus($urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0,
                           p_lvl, l_lvl, b_rnd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
